bin_to_bcd_conv: RTL and testbench
==================================

# bin_to_bcd_conv

Sequential binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) method, processing one binary bit per clock. It produces the packed BCD digits that feed the seven-segment decoder chain for credit and price display in the candy vending system. A start/busy/done handshake lets the control FSM launch a conversion and sample the result.

## Interface
- W, 8: binary input width.
- D, 3: number of BCD output digits. Must satisfy 10^D > 2^W − 1; this is checked by elaboration assertion.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  W  unsigned binary value; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd is valid from this cycle onward.
- bcd  out  4*D  packed BCD; digit i occupies bits [4i+3:4i], and digit 0 is the least significant.

## Operation
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Clock port is clk; reset port is rst.
- States: IDLE, SHIFT, DONE.
- Reset:
  - state = IDLE.
  - busy = 0, done = 0, bcd = 0.
  - Internal shift register and bit counter cleared.
- IDLE:
  - When start = 1: load bin into the binary shift field, clear the BCD work field, set counter = W, go to SHIFT.
  - When start = 0: remain in IDLE.
- SHIFT, once per cycle:
  - Every 4-bit work digit ≥ 5 gets +3. All digits are corrected in parallel, from the current values.
  - Then the combined {work, binary} register shifts left by 1.
  - Counter decrements by 1.
  - When the counter reaches 1 on this edge (the W-th shift), copy the post-shift work field to bcd and go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
- start behaviour outside IDLE:
  - start is ignored in SHIFT and DONE; no queuing.
  - bin changes after the accepted edge have no effect.
- Output holding: bcd holds the last result until the next DONE. It is not cleared at start.
- Arithmetic:
  - The work field is 4*D bits; the combined register is 4*D + W bits.
  - The add-3 operation is per-digit and must not carry across digit boundaries.
- Outputs busy, done and bcd are registered; there is no combinational path from inputs to outputs.

## Timing
- Start sampled at edge k:
  - busy = 1 for cycles k+1 … k+W (W cycles).
  - At edge k+W: bcd is updated and done = 1 for cycle k+W+1. busy = 0 in that cycle.
  - At edge k+W+1: return to IDLE. The earliest next accepted start is sampled at edge k+W+2.
- Latency from start to done: W+1 cycles (9 for W = 8).
- Throughput: one conversion per W+2 cycles.
- Reset asserted mid-conversion: on the next edge, return to IDLE with busy = 0, done = 0, bcd = 0. No done pulse for the aborted conversion.
- Reset and start high on the same edge: reset wins, and start is dropped.
- Boundary inputs:
  - bin = 0 → bcd = 0.
  - bin = 2^W − 1 → the full-scale decimal value (255 → 0x255). No overflow is possible given the D constraint.

## Test plan
- Reset, then start with bin = 0 → done at cycle 9 after start; bcd = 12'h000; busy high for exactly 8 cycles.
- bin = 8'd255 → bcd = 12'h255 with done on the 9th cycle; bin = 8'd99 → 12'h099; bin = 8'd100 → 12'h100. Also sweep all 256 values against a reference model.
- start = 1 with bin = 8'd7 while busy from a bin = 8'd42 conversion → result 12'h042; only one done pulse; the request is not queued. Held-high start → conversions repeat every 10 cycles.
- rst pulsed at the 4th busy cycle of bin = 8'd200 → next cycle busy = 0, bcd = 0, no done. A fresh start with bin = 8'd17 then gives 12'h017.
- Change bin to 8'd1 one cycle after the accepted start of bin = 8'd128 → bcd = 12'h128.
- Parameters W = 10, D = 4: bin = 1023 → bcd = 16'h1023, done 11 cycles after start; bin = 999 → 16'h0999.

Source files
------------

// File: rtl/bin_to_bcd_conv.sv
// bin_to_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Produces packed BCD digits for the seven-segment display chain (credit / price).
//
// Parameters:
//   W  binary input width
//   D  number of BCD output digits (10^D must exceed 2^W - 1)
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  conversion request, sampled only while idle
//   bin    unsigned binary value, captured on the accepted start edge
//   busy   high while a conversion is in progress (registered)
//   done   one-cycle pulse, bcd valid from this cycle onward (registered)
//   bcd    packed BCD, digit i in bits [4i+3:4i], digit 0 least significant (registered)
module bin_to_bcd_conv #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     bin,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd
);

  localparam int unsigned BcdW = 4 * D;
  localparam int unsigned RegW = BcdW + W;
  localparam int unsigned CntW = $clog2(W + 1);

  // Elaboration-time check that D digits can hold the full-scale binary value.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned MaxBin = (64'd1 << W) - 64'd1;

  if (pow10(D) <= MaxBin) begin : g_bad_digits
    $error("bin_to_bcd_conv: D digits cannot represent 2^W - 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [RegW-1:0]   sreg_q, sreg_d;    // {work digits, binary remainder}
  logic [CntW-1:0]   cnt_q, cnt_d;      // shifts remaining
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              busy_q, done_q;

  logic [BcdW-1:0]   work;
  logic [BcdW-1:0]   corr;
  logic [RegW-1:0]   shifted;

  // Add-3 correction on every digit in parallel, no carry between digits, then shift left.
  always_comb begin
    work = sreg_q[RegW-1:W];
    corr = work;
    for (int unsigned i = 0; i < D; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end else begin
        corr[4*i +: 4] = work[4*i +: 4];
      end
    end
    shifted = {corr, sreg_q[W-1:0]} << 1;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sreg_d  = {{BcdW{1'b0}}, bin};
          cnt_d   = CntW'(W);
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = shifted;
        cnt_d  = cnt_q - CntW'(1);
        // Last of the W shifts: publish the post-shift work field.
        if (cnt_q == CntW'(1)) begin
          bcd_d   = shifted[RegW-1:W];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_d == StShift);
      done_q  <= (state_d == StDone);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Directed self-checking bench for bin_to_bcd_conv (W=8/D=3 and W=10/D=4 instances).
module tb_bin_to_bcd_conv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  logic        start10;
  logic [9:0]  bin10;
  logic        busy10;
  logic        done10;
  logic [15:0] bcd10;

  int n_checks;
  int n_fail;

  bin_to_bcd_conv #(.W(8), .D(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  bin_to_bcd_conv #(.W(10), .D(4)) dut10 (
    .clk   (clk),
    .rst   (rst),
    .start (start10),
    .bin   (bin10),
    .busy  (busy10),
    .done  (done10),
    .bcd   (bcd10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; drive and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  // Launch one W=8 conversion; post_bin is driven on bin right after the accepted edge.
  task automatic run_conv(input string tag, input logic [7:0] val, input logic [7:0] post_bin,
                          input logic [11:0] exp);
    int n;
    int busy_cnt;
    bin   = val;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = post_bin;
    n = 1;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " busy cycles"}, busy_cnt, 8);
    check({tag, " busy low at done"}, busy, 0);
    check({tag, " bcd"}, bcd, exp);
    tick();
    check({tag, " done one cycle"}, done, 0);
  endtask

  task automatic run_conv10(input string tag, input logic [9:0] val, input logic [15:0] exp);
    int n;
    bin10   = val;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    n = 1;
    while (!done10 && n < 25) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 11);
    check({tag, " bcd"}, bcd10, exp);
    tick();
  endtask

  initial begin
    int pulses[$];
    int dcnt;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    start10  = 1'b0;
    bin10    = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bcd", bcd, 0);
    check("reset busy10", busy10, 0);

    run_conv("zero", 8'd0, 8'd0, 12'h000);
    run_conv("full scale", 8'd255, 8'd255, 12'h255);
    run_conv("99", 8'd99, 8'd99, 12'h099);
    run_conv("100", 8'd100, 8'd100, 12'h100);
    run_conv("bin change", 8'd128, 8'd1, 12'h128);

    // start held with a different bin while busy: ignored, not queued
    bin = 8'd42;
    start = 1'b1;
    tick();
    bin = 8'd7;
    dcnt = 0;
    for (int c = 0; c < 20 && dcnt == 0; c++) begin
      tick();
      if (done) begin
        dcnt++;
        start = 1'b0;
      end
    end
    check("ignore start bcd", bcd, 12'h042);
    check("ignore start one done", dcnt, 1);
    tick();
    check("no queue done", done, 0);
    tick();
    check("no queue busy", busy, 0);

    // held-high start repeats every W+2 cycles
    bin = 8'd5;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) pulses.push_back(c);
    end
    start = 1'b0;
    check("held start pulses", pulses.size() >= 3, 1);
    if (pulses.size() >= 3) begin
      check("held start period 1", pulses[1] - pulses[0], 10);
      check("held start period 2", pulses[2] - pulses[1], 10);
    end
    check("held start bcd", bcd, 12'h005);
    for (int c = 0; c < 12; c++) tick();

    // reset during the 4th busy cycle aborts with no done
    bin = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort busy before rst", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort bcd", bcd, 0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort no done", dcnt, 0);
    run_conv("after abort", 8'd17, 8'd17, 12'h017);

    // reset and start on the same edge: start dropped
    bin = 8'd33;
    start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst+start busy", busy, 0);
    tick();
    check("rst+start dropped", busy, 0);

    run_conv10("w10 1023", 10'd1023, 16'h1023);
    run_conv10("w10 999", 10'd999, 16'h0999);

    for (int v = 0; v < 256; v++) begin
      run_conv("sweep", 8'(v), 8'(v), ref_bcd(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
